// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns the debounced button level into one-cycle event pulses: single click,
// double click, long press and, when BTN_AUTO_REPEAT_EN is defined, an
// auto-repeat tick while the button stays held after a long press.
// The input is already clean and in the clk domain, so there is no synchronizer.
//
// state          | meaning
// IDLE           | waiting for a fresh press (a rise on btn)
// PRESSED        | first press in progress, timing toward long press
// WAIT_SECOND    | released, timing the window for a second press
// SECOND_PRESSED | second press in progress; release gives a double click
// LONG_HELD      | long press reported, waiting for release (repeat ticks)
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES   = 100_000_000,
  parameter int DOUBLE_CLICK_CYCLES = 30_000_000,
  parameter int REPEAT_CYCLES       = 20_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic held
);

  localparam int MAX_LD  = (LONG_PRESS_CYCLES > DOUBLE_CLICK_CYCLES) ?
                           LONG_PRESS_CYCLES : DOUBLE_CLICK_CYCLES;
  localparam int MAX_ALL = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] LONG_TC = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] DBL_TC  = CW'(DOUBLE_CLICK_CYCLES - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYCLES - 1);
`endif

  // Reject parameter values that would make a terminal count unreachable.
  if (LONG_PRESS_CYCLES < 2) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must be at least 2");
  end
  if (DOUBLE_CLICK_CYCLES < 2) begin : g_bad_dbl
    $error("DOUBLE_CLICK_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("REPEAT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    WAIT_SECOND    = 3'd2,
    SECOND_PRESSED = 3'd3,
    LONG_HELD      = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          btn_q;
  logic          rise;
  logic          single_next, double_next, long_next, held_next;
`ifdef BTN_AUTO_REPEAT_EN
  logic          repeat_next;
`endif

  // btn_q resets high so a button held through reset never looks like a rise.
  assign rise = btn & ~btn_q;

  // State, shared counter and input history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      btn_q <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      btn_q <= btn;
    end
  end

  // Registered event pulses and held level; reset discards anything pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
    end else begin
      single_click <= single_next;
      double_click <= double_next;
      long_press   <= long_next;
      held         <= held_next;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  // Auto-repeat pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      repeat_tick <= 1'b0;
    end else begin
      repeat_tick <= repeat_next;
    end
  end
`else
  assign repeat_tick = 1'b0;
`endif

  // Next-state, counter and event decode; release wins over a terminal count.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt + ONE;
    single_next = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    repeat_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rise) begin
          state_next = PRESSED;
        end
      end
      PRESSED: begin
        if (!btn) begin
          state_next = WAIT_SECOND;
          cnt_next   = '0;
        end else if (cnt == LONG_TC) begin
          state_next = LONG_HELD;
          cnt_next   = '0;
          long_next  = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (btn) begin
          state_next = SECOND_PRESSED;
          cnt_next   = '0;
        end else if (cnt == DBL_TC) begin
          state_next  = IDLE;
          cnt_next    = '0;
          single_next = 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (!btn) begin
          state_next  = IDLE;
          cnt_next    = '0;
          double_next = 1'b1;
        end else if (cnt == LONG_TC) begin
          // The pending double click is dropped in favour of the long press.
          state_next = LONG_HELD;
          cnt_next   = '0;
          long_next  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          if (cnt == REP_TC) begin
            cnt_next    = '0;
            repeat_next = 1'b1;
          end
`else
          cnt_next = '0;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    held_next = (state_next == PRESSED) || (state_next == SECOND_PRESSED) ||
                (state_next == LONG_HELD);
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with L=8, D=4, R=3.
// Stimulus pushes the expected event kind and the posedge index after which it
// must be visible; the monitor pops and compares whenever any event pulses.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int D = 4;
  localparam int R = 3;

  localparam int K_SINGLE = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;
  localparam int K_REPEAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b1;
  logic single_click, double_click, long_press, repeat_tick, held;

  button_event_decoder #(
    .LONG_PRESS_CYCLES  (L),
    .DOUBLE_CLICK_CYCLES(D),
    .REPEAT_CYCLES      (R)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .held        (held)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int kind;
    int edge_n;
  } ev_t;
  ev_t exp_q[$];

  task automatic expect_ev(input int kind, input int e);
    ev_t ev;
    ev.kind = kind;
    ev.edge_n = e;
    exp_q.push_back(ev);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  task automatic pop_cmp(input int kind);
    ev_t ev;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, required no event",
               kind, edge_cnt);
    end else begin
      ev = exp_q.pop_front();
      if (ev.kind != kind || ev.edge_n != edge_cnt) begin
        errors++;
        $display("FAIL event_match: got kind %0d at edge %0d, required kind %0d at edge %0d",
                 kind, edge_cnt, ev.kind, ev.edge_n);
      end
    end
  endtask

  // Drive btn to v for the next n sampling edges; returns #1 after the last.
  task automatic hold(input logic v, input int n);
    btn = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_single"}, int'(single_click), 0);
    check({name, "_double"}, int'(double_click), 0);
    check({name, "_long"},   int'(long_press),   0);
    check({name, "_repeat"}, int'(repeat_tick),  0);
    check({name, "_held"},   int'(held),         0);
  endtask

  // Monitor: every event pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    int n;
    n = int'(single_click) + int'(double_click) + int'(long_press) + int'(repeat_tick);
    if (n != 0) begin
      check("one_hot_events", n, 1);
      if (single_click) pop_cmp(K_SINGLE);
      if (double_click) pop_cmp(K_DOUBLE);
      if (long_press)   pop_cmp(K_LONG);
      if (repeat_tick)  pop_cmp(K_REPEAT);
    end
  end

  initial begin
    int t;

    // Reset with the button already pressed.
    reset = 1'b1;
    btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;

    // Held through reset: no events, held stays low.
    hold(1'b1, 20);
    check("held_through_reset", int'(held), 0);
    hold(1'b0, 3);
    t = edge_cnt + 1;
    expect_ev(K_SINGLE, t + 6);
    hold(1'b1, 1);
    check("held_rise", int'(held), 1);
    hold(1'b1, 1);
    hold(1'b0, 10);
    check("held_after_click", int'(held), 0);

    // Short press: 3 high, then release.
    t = edge_cnt + 1;
    expect_ev(K_SINGLE, t + 7);
    hold(1'b1, 3);
    hold(1'b0, 12);

    // Double click: high 2, low 2, high 2, low.
    t = edge_cnt + 1;
    expect_ev(K_DOUBLE, t + 6);
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 2);
    check("held_second_press", int'(held), 1);
    hold(1'b0, 10);

    // Long press held 20 cycles, with repeat ticks when compiled in.
    t = edge_cnt + 1;
    expect_ev(K_LONG, t + 8);
`ifdef BTN_AUTO_REPEAT_EN
    expect_ev(K_REPEAT, t + 11);
    expect_ev(K_REPEAT, t + 14);
    expect_ev(K_REPEAT, t + 17);
`endif
    hold(1'b1, 20);
    check("held_long", int'(held), 1);
    hold(1'b0, 10);
    check("held_after_long", int'(held), 0);

    // Release sampled exactly when cnt reaches L-1: click, not long press.
    t = edge_cnt + 1;
    expect_ev(K_SINGLE, t + 12);
    hold(1'b1, 8);
    hold(1'b0, 12);

    // Second press sampled on the last cycle of the window: still a double.
    t = edge_cnt + 1;
    expect_ev(K_DOUBLE, t + 8);
    hold(1'b1, 2);
    hold(1'b0, 4);
    hold(1'b1, 2);
    hold(1'b0, 10);

    // One cycle later the window has closed: two separate single clicks.
    t = edge_cnt + 1;
    expect_ev(K_SINGLE, t + 6);
    expect_ev(K_SINGLE, t + 13);
    hold(1'b1, 2);
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 12);

    // Second press held to the long threshold: long press, no double.
    t = edge_cnt + 1;
    expect_ev(K_LONG, t + 12);
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Third press right after a double click starts a fresh sequence.
    t = edge_cnt + 1;
    expect_ev(K_DOUBLE, t + 6);
    expect_ev(K_SINGLE, t + 13);
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 2);
    hold(1'b0, 12);

    // Reset during WAIT_SECOND discards the pending single click.
    hold(1'b1, 2);
    hold(1'b0, 2);
    reset = 1'b1;
    #1;
    check_quiet("reset_mid");
    hold(1'b0, 2);
    reset = 1'b0;
    hold(1'b0, 10);
    check("held_after_reset_mid", int'(held), 0);

    hold(1'b0, 5);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
